// File: rtl/rst_seq_ctrl.sv
// DCM/PLL reset pulse, debounced lock wait with bounded retries,
// then staggered release of N_CH downstream resets.
module rst_seq_ctrl #(
    parameter int N_CH         = 3,
    parameter int DCM_RST_CYC  = 128,
    parameter int LOCK_FILT    = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int REL_DLY      = 2048,
    parameter int MAX_RETRY    = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic            pci_clk_in,
    input  logic            RESET,
    input  logic            locked_in,
    output logic            dcm_rst_out,
    output logic [N_CH-1:0] rst_out,
    output logic            all_ready,
    output logic            fault,
    output logic [RW-1:0]   retry_cnt,
    output logic [2:0]      state_o
);

    localparam int MAX_A = (DCM_RST_CYC > LOCK_TIMEOUT) ? DCM_RST_CYC : LOCK_TIMEOUT;
    localparam int MAX_C = (MAX_A > REL_DLY) ? MAX_A : REL_DLY;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int CIW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FW    = $clog2(LOCK_FILT + 1);

    localparam logic [CW-1:0]  DCM_LAST  = CW'(DCM_RST_CYC - 1);
    localparam logic [CW-1:0]  TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]  REL_LAST  = CW'(REL_DLY - 1);
    localparam logic [CIW-1:0] CH_LAST   = CIW'(N_CH - 1);
    localparam logic [FW-1:0]  FILT_N    = FW'(LOCK_FILT);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_DCM_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CIW-1:0] ch_idx;
    logic           lock_s1;
    logic           lock_s2;
    logic [FW-1:0]  fcnt;
    logic           lock_f;

    // fcnt saturates at LOCK_FILT; lock drops the first synced-low cycle
    assign lock_f  = lock_s2 && (fcnt == FILT_N);
    assign state_o = state;

    always_ff @(posedge pci_clk_in) begin
        if (RESET) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            fcnt    <= '0;
        end else begin
            lock_s1 <= locked_in;
            lock_s2 <= lock_s1;
            if (!lock_s2)
                fcnt <= '0;
            else if (fcnt != FILT_N)
                fcnt <= fcnt + 1'b1;
        end
    end

    always_ff @(posedge pci_clk_in) begin
        if (RESET) begin
            state       <= S_DCM_RST;
            cnt         <= '0;
            ch_idx      <= '0;
            dcm_rst_out <= 1'b1;
            rst_out     <= '1;
            all_ready   <= 1'b0;
            fault       <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            unique case (state)
                S_DCM_RST: begin
                    dcm_rst_out <= 1'b1;
                    rst_out     <= '1;
                    if (cnt == DCM_LAST) begin
                        state       <= S_WAIT_LOCK;
                        cnt         <= '0;
                        dcm_rst_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_f) begin
                        state  <= S_RELEASE;
                        cnt    <= '0;
                        ch_idx <= '0;
                    end else if (cnt == TO_LAST) begin
                        cnt         <= '0;
                        dcm_rst_out <= 1'b1;
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_DCM_RST;
                        end else begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!lock_f) begin
                        state       <= S_DCM_RST;
                        cnt         <= '0;
                        ch_idx      <= '0;
                        rst_out     <= '1;
                        dcm_rst_out <= 1'b1;
                    end else if (cnt == REL_LAST) begin
                        cnt             <= '0;
                        rst_out[ch_idx] <= 1'b0;
                        if (ch_idx == CH_LAST) begin
                            state     <= S_RUN;
                            all_ready <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_f) begin
                        state       <= S_DCM_RST;
                        cnt         <= '0;
                        ch_idx      <= '0;
                        rst_out     <= '1;
                        all_ready   <= 1'b0;
                        dcm_rst_out <= 1'b1;
                    end
                end
                S_FAULT: begin
                    dcm_rst_out <= 1'b1;
                    rst_out     <= '1;
                    fault       <= 1'b1;
                end
                default: begin
                    state <= S_DCM_RST;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
